control_puerta: RTL and testbench

Door controller that consumes the inside-button request produced by the button front-end and acknowledges it. It runs the door open/hold/close cycle with timed motor outputs and reverses the door on an obstacle. It sits between the button logic and the door motor driver and status indicators. Timing is counted in clock cycles, so no absolute-time dependency exists.

---
 rtl/puerta_pkg.sv | 20 ++
 rtl/control_puerta_if.sv | 22 ++
 rtl/temporizador_puerta.sv | 37 +++
 rtl/control_puerta.sv | 107 ++++++++++
 tb/tb_control_puerta.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/puerta_pkg.sv
// Shared door-controller types: the four door states and the code shown on state_o.
package puerta_pkg;

    typedef enum logic [1:0] {
        CERRADA  = 2'd0,
        ABRIENDO = 2'd1,
        ABIERTA  = 2'd2,
        CERRANDO = 2'd3
    } estado_e;

    // Display logic reads state_o through this mapping, so LEDs stay tied to the state names.
    function automatic logic [1:0] codigo_estado(estado_e s);
        return 2'(s);
    endfunction

    function automatic int maxInt(int a, int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/control_puerta_if.sv
// Button/sensor inputs and motor/status outputs of the door controller, bundled as one port.
interface puerta_if;

    logic       btn_req;
    logic       obstacle;
    logic       req_ack;
    logic       motor_open;
    logic       motor_close;
    logic       door_open;
    logic [1:0] state_o;

    modport master (
        output btn_req, obstacle,
        input  req_ack, motor_open, motor_close, door_open, state_o
    );

    modport slave (
        input  btn_req, obstacle,
        output req_ack, motor_open, motor_close, door_open, state_o
    );

endinterface

// File: rtl/temporizador_puerta.sv
// Loadable down-counter that stops at zero; times door travel and dwell phases.
module temporizador_puerta #(
    parameter int TW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [TW-1:0] load_val_i,
    output logic [TW-1:0] cnt_o,
    output logic          zero_o
);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // A load always wins over the countdown; an idle counter rests at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/control_puerta.sv
// Door controller FSM: open/hold/close cycle with dwell extension and obstacle reversal.
module control_puerta
    import puerta_pkg::*;
#(
    parameter int T_MOVE = 4,
    parameter int T_HOLD = 8
) (
    input  logic     clk,
    input  logic     rst,
    puerta_if.slave  bus
);

    localparam int TW = $clog2(maxInt(T_MOVE, T_HOLD));
    localparam logic [TW-1:0] MOVE_LAST = TW'(T_MOVE - 1);
    localparam logic [TW-1:0] HOLD_LAST = TW'(T_HOLD - 1);

    estado_e       state_q;
    estado_e       state_d;
    logic          btn_q;
    logic          ack_q;
    logic          ack_d;
    logic          load;
    logic [TW-1:0] load_val;
    logic [TW-1:0] cnt;
    logic          zero;
    logic          req_evt;

    assign req_evt = bus.btn_req & ~btn_q;

    temporizador_puerta #(.TW(TW)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load),
        .load_val_i (load_val),
        .cnt_o      (cnt),
        .zero_o     (zero)
    );

    // Reversing from CERRANDO reloads with the distance already closed, so the door reopens exactly that far.
    always_comb begin
        state_d  = state_q;
        ack_d    = 1'b0;
        load     = 1'b0;
        load_val = '0;
        case (state_q)
            CERRADA: begin
                if (req_evt) begin
                    state_d  = ABRIENDO;
                    load     = 1'b1;
                    load_val = MOVE_LAST;
                    ack_d    = 1'b1;
                end
            end
            ABRIENDO: begin
                if (zero) begin
                    state_d  = ABIERTA;
                    load     = 1'b1;
                    load_val = HOLD_LAST;
                end
            end
            ABIERTA: begin
                if (req_evt) begin
                    load     = 1'b1;
                    load_val = HOLD_LAST;
                    ack_d    = 1'b1;
                end else if (bus.obstacle) begin
                    load     = 1'b1;
                    load_val = HOLD_LAST;
                end else if (zero) begin
                    state_d  = CERRANDO;
                    load     = 1'b1;
                    load_val = MOVE_LAST;
                end
            end
            CERRANDO: begin
                if (bus.obstacle || req_evt) begin
                    state_d  = ABRIENDO;
                    load     = 1'b1;
                    load_val = MOVE_LAST - cnt;
                    ack_d    = req_evt;
                end else if (zero) begin
                    state_d  = CERRADA;
                end
            end
            default: state_d = CERRADA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CERRADA;
            btn_q   <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            btn_q   <= bus.btn_req;
            ack_q   <= ack_d;
        end
    end

    assign bus.req_ack     = ack_q;
    assign bus.motor_open  = (state_q == ABRIENDO);
    assign bus.motor_close = (state_q == CERRANDO);
    assign bus.door_open   = (state_q == ABIERTA);
    assign bus.state_o     = codigo_estado(state_q);

endmodule

// File: tb/tb_control_puerta.sv
// Self-checking bench for control_puerta: door-position model compared every cycle plus literal duration checks.
module tb_control_puerta;

    localparam int T_MOVE = 4;
    localparam int T_HOLD = 8;

    logic clk;
    logic rst;
    int   asserts;
    int   failures;
    bit   checking;

    int   cntOpen;
    int   cntDwell;
    int   cntClose;
    int   cntAck;

    // Model: phase 0 closed, 1 opening, 2 open, 3 closing; mPos = cycles still to travel to fully open.
    int   mPhase;
    int   mPos;
    int   mDwell;
    bit   mAck;
    bit   mPrev;
    bit   evt;

    puerta_if bus ();

    control_puerta #(.T_MOVE(T_MOVE), .T_HOLD(T_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        asserts++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Door walks a distance of T_MOVE steps; dwell counts cycles remaining while open.
    always @(posedge clk) begin
        evt = bus.btn_req && !mPrev;
        if (rst) begin
            mPhase = 0;
            mPos   = T_MOVE;
            mDwell = 0;
            mAck   = 0;
            mPrev  = 0;
        end else begin
            mAck = 0;
            case (mPhase)
                0: if (evt) begin
                    mPhase = 1;
                    mPos   = T_MOVE;
                    mAck   = 1;
                end
                1: begin
                    mPos = mPos - 1;
                    if (mPos == 0) begin
                        mPhase = 2;
                        mDwell = T_HOLD;
                    end
                end
                2: begin
                    mDwell = mDwell - 1;
                    if (evt) begin
                        mDwell = T_HOLD;
                        mAck   = 1;
                    end else if (bus.obstacle) begin
                        mDwell = T_HOLD;
                    end else if (mDwell == 0) begin
                        mPhase = 3;
                        mPos   = 0;
                    end
                end
                default: begin
                    mPos = mPos + 1;
                    if (bus.obstacle || evt) begin
                        mPhase = 1;
                        mAck   = evt;
                    end else if (mPos == T_MOVE) begin
                        mPhase = 0;
                    end
                end
            endcase
            mPrev = bus.btn_req;
        end
    end

    // Every-cycle comparison against the model, plus duration counters for the literal checks.
    always @(negedge clk) begin
        if (checking) begin
            checkOutput("state_o", int'(bus.state_o), mPhase);
            checkOutput("motor_open", int'(bus.motor_open), int'(mPhase == 1));
            checkOutput("door_open", int'(bus.door_open), int'(mPhase == 2));
            checkOutput("motor_close", int'(bus.motor_close), int'(mPhase == 3));
            checkOutput("req_ack", int'(bus.req_ack), int'(mAck));
            checkOutput("motors_exclusive", int'(bus.motor_open && bus.motor_close), 0);
            cntOpen  += int'(bus.motor_open);
            cntDwell += int'(bus.door_open);
            cntClose += int'(bus.motor_close);
            cntAck   += int'(bus.req_ack);
        end
    end

    task automatic clearCounters();
        cntOpen  = 0;
        cntDwell = 0;
        cntClose = 0;
        cntAck   = 0;
    endtask

    task automatic applyStimulus(input bit btn, input bit obs, input int n);
        bus.btn_req  = btn;
        bus.obstacle = obs;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        asserts     = 0;
        failures    = 0;
        checking    = 0;
        rst         = 1'b1;
        bus.btn_req  = 1'b0;
        bus.obstacle = 1'b0;
        clearCounters();
        repeat (2) @(posedge clk);
        #2;
        rst      = 1'b0;
        checking = 1;

        checkOutput("reset_state", int'(bus.state_o), 0);
        checkOutput("reset_outputs", int'({bus.req_ack, bus.motor_open, bus.motor_close, bus.door_open}), 0);

        $display("[TB] Test 1: held button, full cycle");
        clearCounters();
        applyStimulus(1, 0, 20);
        applyStimulus(0, 0, 2);
        checkOutput("t1_open_cycles", cntOpen, 4);
        checkOutput("t1_dwell_cycles", cntDwell, 8);
        checkOutput("t1_close_cycles", cntClose, 4);
        checkOutput("t1_acks", cntAck, 1);
        checkOutput("t1_final_state", int'(bus.state_o), 0);

        $display("[TB] Test 2: dwell extension");
        clearCounters();
        applyStimulus(1, 0, 1);
        applyStimulus(0, 0, 8);
        applyStimulus(1, 0, 1);
        applyStimulus(0, 0, 15);
        checkOutput("t2_dwell_cycles", cntDwell, 13);
        checkOutput("t2_acks", cntAck, 2);
        checkOutput("t2_close_cycles", cntClose, 4);

        $display("[TB] Test 3: obstacle while closing");
        applyStimulus(1, 0, 1);
        applyStimulus(0, 0, 14);
        applyStimulus(0, 1, 1);
        clearCounters();
        applyStimulus(0, 0, 16);
        checkOutput("t3_reopen_cycles", cntOpen, 3);
        checkOutput("t3_dwell_cycles", cntDwell, 8);
        checkOutput("t3_acks", cntAck, 0);
        checkOutput("t3_final_state", int'(bus.state_o), 0);

        $display("[TB] Test 4: obstacle held while open");
        applyStimulus(1, 0, 1);
        applyStimulus(0, 0, 4);
        clearCounters();
        applyStimulus(0, 1, 20);
        checkOutput("t4_dwell_held", cntDwell, 20);
        clearCounters();
        applyStimulus(0, 0, 8);
        checkOutput("t4_dwell_after_drop", cntDwell, 8);
        checkOutput("t4_no_close_yet", cntClose, 0);
        applyStimulus(0, 0, 1);
        checkOutput("t4_close_started", cntClose, 1);
        applyStimulus(0, 0, 5);
        checkOutput("t4_final_state", int'(bus.state_o), 0);

        $display("[TB] Test 5: press while opening");
        clearCounters();
        applyStimulus(1, 0, 1);
        applyStimulus(0, 0, 1);
        applyStimulus(1, 0, 1);
        applyStimulus(0, 0, 20);
        checkOutput("t5_open_cycles", cntOpen, 4);
        checkOutput("t5_acks", cntAck, 1);

        $display("[TB] Test 6: reset while closing");
        applyStimulus(1, 0, 1);
        applyStimulus(0, 0, 13);
        checkOutput("t6_closing", int'(bus.state_o), 3);
        rst = 1'b1;
        applyStimulus(0, 0, 1);
        rst = 1'b0;
        checkOutput("t6_reset_state", int'(bus.state_o), 0);
        checkOutput("t6_reset_outputs", int'({bus.req_ack, bus.motor_open, bus.motor_close, bus.door_open}), 0);
        clearCounters();
        applyStimulus(1, 0, 1);
        applyStimulus(0, 0, 20);
        checkOutput("t6_open_cycles", cntOpen, 4);
        checkOutput("t6_dwell_cycles", cntDwell, 8);
        checkOutput("t6_close_cycles", cntClose, 4);
        checkOutput("t6_acks", cntAck, 1);

        checking = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
